// File: rtl/grn_attractor_finder.sv
// Sequential driver for a Boolean gene-regulatory-network next-state block.
// It iterates from a loaded state until it finds a fixed point, a short cycle or a timeout.
module grn_attractor_finder #(
    parameter int WIDTH = 20,
    parameter int HIST = 8,
    parameter int MAX_STEPS = 1024,
    localparam int PW = $clog2(HIST) + 1,
    localparam int SW = $clog2(MAX_STEPS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] init_state,
    output logic [WIDTH-1:0] grn_in,
    input  logic [WIDTH-1:0] grn_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result_type,
    output logic [PW-1:0]    period,
    output logic [SW-1:0]    steps,
    output logic [WIDTH-1:0] attractor_state
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cur;
    logic [SW-1:0]    step_cnt;
    // hist[0] is cur itself, so only the older entries are stored
    logic [WIDTH-1:0] hist [1:HIST-1];
    logic [HIST-1:1]  hv;
    logic             hit;
    logic [PW-1:0]    hit_k;
    logic             timeout;

    assign grn_in  = cur;
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign timeout = (step_cnt == SW'(MAX_STEPS - 1));

    // Scan oldest to newest so the lowest matching k is the one kept
    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        for (int k = HIST - 1; k >= 1; k--) begin
            if (hv[k] && hist[k] == grn_out) begin
                hit   = 1'b1;
                hit_k = PW'(k);
            end
        end
        if (grn_out == cur) begin
            hit   = 1'b1;
            hit_k = '0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (hit || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cur             <= '0;
            step_cnt        <= '0;
            hv              <= '0;
            result_type     <= '0;
            period          <= '0;
            steps           <= '0;
            attractor_state <= '0;
            for (int k = 1; k < HIST; k++) hist[k] <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cur      <= init_state;
                        hv       <= '0;
                        step_cnt <= '0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        result_type     <= (hit_k == '0) ? 2'd0 : 2'd1;
                        period          <= hit_k + PW'(1);
                        steps           <= step_cnt;
                        attractor_state <= grn_out;
                    end else if (timeout) begin
                        result_type     <= 2'd2;
                        period          <= '0;
                        steps           <= SW'(MAX_STEPS);
                        attractor_state <= grn_out;
                    end else begin
                        hist[1] <= cur;
                        hv[1]   <= 1'b1;
                        for (int k = 2; k < HIST; k++) begin
                            hist[k] <= hist[k-1];
                            hv[k]   <= hv[k-1];
                        end
                        cur      <= grn_out;
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grn_attractor_finder.sv
// Bench for grn_attractor_finder: trajectory-based reference model,
// directed maps with literal pins, plus randomized maps run back-to-back.
module tb_grn_attractor_finder;

    localparam int W    = 20;
    localparam int HIST = 8;
    localparam int MAXS = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  init_state;
    logic [W-1:0]  grn_in;
    logic [W-1:0]  grn_out;
    logic          busy;
    logic          done;
    logic [1:0]    result_type;
    logic [3:0]    period;
    logic [10:0]   steps;
    logic [W-1:0]  attractor_state;

    int            mode;
    logic [31:0]   ra, rb, rm;
    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  traj [0:MAXS];

    grn_attractor_finder #(.WIDTH(W), .HIST(HIST), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start), .init_state(init_state),
        .grn_in(grn_in), .grn_out(grn_out), .busy(busy), .done(done),
        .result_type(result_type), .period(period), .steps(steps),
        .attractor_state(attractor_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] fmap(input int m, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] mm,
                                          input logic [W-1:0] x);
        logic [31:0] t;
        case (m)
            0: return x;
            1: return x >> 1;
            2: return {x[W-1:2], x[1:0] + 2'd1};
            3: return x + 20'd1;
            4: return {x[W-1:4], x[3:0] + 4'd1};
            default: begin
                t = ({12'd0, x} * a + b) ^ {14'd0, x[W-1:2]};
                return W'(t % mm);
            end
        endcase
    endfunction

    always_comb grn_out = fmap(mode, ra, rb, rm, grn_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Walk the trajectory; the most recent HIST states are the searchable history
    task automatic model(input logic [W-1:0] init, output logic [1:0] typ,
                         output logic [3:0] per, output logic [10:0] stp,
                         output logic [W-1:0] att);
        int n = 0;
        bit fin = 0;
        logic [W-1:0] nx;
        typ = 0; per = 0; stp = 0; att = 0;
        traj[0] = init;
        while (!fin) begin
            nx = fmap(mode, ra, rb, rm, traj[n]);
            for (int k = 0; k < HIST && !fin; k++) begin
                if (n - k >= 0 && traj[n-k] == nx) begin
                    fin = 1;
                    typ = (k == 0) ? 2'd0 : 2'd1;
                    per = 4'(k + 1);
                    stp = 11'(n);
                    att = nx;
                end
            end
            if (!fin && n + 1 == MAXS) begin
                fin = 1; typ = 2; per = 0; stp = 11'(MAXS); att = nx;
            end
            if (!fin) begin
                traj[n+1] = nx;
                n++;
            end
        end
    endtask

    task automatic run(input logic [W-1:0] init, input bit poke_start);
        logic [1:0] typ;
        logic [3:0] per;
        logic [10:0] stp;
        logic [W-1:0] att;
        int lat = 0;
        int explat;
        model(init, typ, per, stp, att);
        explat = (typ == 2) ? int'(stp) + 1 : int'(stp) + 2;
        init_state = init;
        start = 1'b1;
        for (int c = 1; c <= MAXS + 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (poke_start && c == 3) begin
                start = 1'b1;
                init_state = init ^ 20'h5a5a5;
            end
            if (done) lat = c;
            else chk("busy_in_run", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        if (lat == 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", lat, explat);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("result_type", {30'd0, result_type}, {30'd0, typ});
        chk("period", {28'd0, period}, {28'd0, per});
        chk("steps", {21'd0, steps}, {21'd0, stp});
        chk("attractor", {12'd0, attractor_state}, {12'd0, att});
        @(posedge clk); #1;
        chk("done_pulse_len", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("held_steps", {21'd0, steps}, {21'd0, stp});
    endtask

    task automatic pin(input int m, input logic [W-1:0] init, input logic [1:0] t,
                       input logic [3:0] p, input logic [10:0] s, input logic [W-1:0] a);
        logic [1:0] typ;
        logic [3:0] per;
        logic [10:0] stp;
        logic [W-1:0] att;
        mode = m;
        model(init, typ, per, stp, att);
        chk("pin_type", {30'd0, typ}, {30'd0, t});
        chk("pin_period", {28'd0, per}, {28'd0, p});
        chk("pin_steps", {21'd0, stp}, {21'd0, s});
        chk("pin_att", {12'd0, att}, {12'd0, a});
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_type", {30'd0, result_type}, 32'd0);
        chk("rst_period", {28'd0, period}, 32'd0);
        chk("rst_steps", {21'd0, steps}, 32'd0);
        chk("rst_att", {12'd0, attractor_state}, 32'd0);
        chk("rst_grn_in", {12'd0, grn_in}, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; init_state = '0;
        mode = 0; ra = 1; rb = 0; rm = 1;
        @(posedge clk); @(posedge clk); #1;
        check_reset_vals();
        rst = 1'b0;

        pin(0, 20'h12345, 2'd0, 4'd1, 11'd0, 20'h12345);
        run(20'h12345, 0);
        pin(1, 20'h00008, 2'd0, 4'd1, 11'd4, 20'h00000);
        run(20'h00008, 0);
        pin(2, 20'h00000, 2'd1, 4'd4, 11'd3, 20'h00000);
        run(20'h00000, 0);
        pin(3, 20'h00000, 2'd2, 4'd0, 11'd1024, 20'h00400);
        run(20'h00000, 0);
        pin(4, 20'h00000, 2'd2, 4'd0, 11'd1024, 20'h00000);
        run(20'h00000, 0);

        // start ignored while running
        mode = 1;
        run(20'h80000, 1);

        // reset mid-run, then a fresh search
        mode = 3;
        init_state = 20'h00000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check_reset_vals();
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("no_done_after_rst", seen, 0);
        mode = 2;
        run(20'h00001, 0);

        // random maps, back-to-back starts
        for (int i = 0; i < 14; i++) begin
            mode = 5;
            ra = $urandom_range(1, 1000);
            rb = $urandom;
            rm = $urandom_range(1, 40);
            run(W'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
